debounce_timer_arbiter: RTL and testbench

Four-channel button debouncer that time-shares one lockout delay timer among four raw push-button inputs. A round-robin arbiter grants the timer to channels as needed. Each channel emits a one-cycle clean pulse per genuine press and ignores bounce on both press and release. It sits between the board push-buttons and the control logic, so one 16-bit counter does the work of four per-button timers.

---
 rtl/debounce_timer_arbiter.sv | 152 +++++++++++++++
 tb/tb_debounce_timer_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_timer_arbiter.sv
// Four-channel push-button debouncer. One 16-bit lockout timer is shared
// round-robin among the channels, each of which settles its press and release.
module debounce_timer_arbiter #(
  parameter int unsigned DELAY_CYCLES = 40000
) (
  input  logic       clk5,
  input  logic       reset,
  input  logic [3:0] raw,
  output logic [3:0] clean,
  output logic [3:0] held,
  output logic       timer_busy,
  output logic [1:0] grant_id
);

  localparam logic [15:0] LAST_COUNT = 16'(DELAY_CYCLES - 1);

  typedef enum logic [1:0] {
    CH_IDLE,
    CH_REQ_P,
    CH_HELD,
    CH_REQ_R
  } ch_state_t;

  typedef enum logic {
    T_IDLE,
    T_RUN
  } arb_state_t;

  logic [3:0] sync1;
  logic [3:0] sraw;

  ch_state_t  ch_state [4];
  ch_state_t  ch_next  [4];
  logic [3:0] clean_next;
  logic [3:0] req;
  logic [3:0] done;

  arb_state_t arb_state;
  arb_state_t arb_next;
  logic [15:0] count;
  logic [1:0]  last_grant;
  logic [1:0]  pick;
  logic        pick_valid;

  // Two-flop synchronizer; nothing downstream ever looks at raw directly.
  // NOTE: every clocked register uses <= so all flops sample pre-edge values
  // and the synchronizer stages really are two distinct cycles apart.
  always_ff @(posedge clk5) begin
    if (reset) begin
      sync1 <= '0;
      sraw  <= '0;
    end else begin
      sync1 <= raw;
      sraw  <= sync1;
    end
  end

  // Per-channel next state. A channel stops requesting once it owns the timer.
  // NOTE: all outputs of this block get a default before the case so no
  // path through it leaves a value unassigned and infers a latch.
  always_comb begin
    clean_next = '0;
    req        = '0;
    held       = '0;
    for (int i = 0; i < 4; i++) begin
      ch_next[i] = ch_state[i];
      unique case (ch_state[i])
        CH_IDLE: begin
          if (sraw[i]) begin
            ch_next[i]    = CH_REQ_P;
            clean_next[i] = 1'b1;
          end
        end
        CH_REQ_P: begin
          req[i] = !(timer_busy && grant_id == 2'(i));
          if (done[i]) ch_next[i] = CH_HELD;
        end
        CH_HELD: begin
          held[i] = 1'b1;
          if (!sraw[i]) ch_next[i] = CH_REQ_R;
        end
        CH_REQ_R: begin
          req[i] = !(timer_busy && grant_id == 2'(i));
          if (done[i]) ch_next[i] = CH_IDLE;
        end
        default: ch_next[i] = CH_IDLE;
      endcase
    end
  end

  // NOTE: reset is synchronous and covers every state register and the
  // counter, so a reset mid-lockout simply abandons the lockout.
  always_ff @(posedge clk5) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) ch_state[i] <= CH_IDLE;
      clean <= '0;
    end else begin
      for (int i = 0; i < 4; i++) ch_state[i] <= ch_next[i];
      clean <= clean_next;
    end
  end

  // Round-robin pick: search last_grant+1 .. last_grant+4, first hit wins.
  always_comb begin
    pick       = last_grant;
    pick_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!pick_valid && req[last_grant + 2'(k)]) begin
        pick       = last_grant + 2'(k);
        pick_valid = 1'b1;
      end
    end
  end

  always_comb begin
    arb_next = arb_state;
    done     = '0;
    unique case (arb_state)
      T_IDLE: begin
        if (pick_valid) arb_next = T_RUN;
      end
      T_RUN: begin
        if (count == LAST_COUNT) begin
          arb_next       = T_IDLE;
          done[grant_id] = 1'b1;
        end
      end
      default: arb_next = T_IDLE;
    endcase
  end

  always_ff @(posedge clk5) begin
    if (reset) begin
      arb_state  <= T_IDLE;
      count      <= '0;
      last_grant <= 2'd3;
      grant_id   <= 2'd0;
    end else begin
      arb_state <= arb_next;
      if (arb_state == T_IDLE && pick_valid) begin
        grant_id   <= pick;
        last_grant <= pick;
        count      <= '0;
      end else if (arb_state == T_RUN) begin
        count <= (count == LAST_COUNT) ? '0 : count + 16'd1;
      end
    end
  end

  assign timer_busy = (arb_state == T_RUN);

endmodule

// File: tb/tb_debounce_timer_arbiter.sv
// Self-checking bench for debounce_timer_arbiter with an 8-cycle lockout.
// Expectations are scheduled on a scoreboard when stimulus is applied.
module tb_debounce_timer_arbiter;

  localparam int D = 8;

  logic       clk5 = 1'b0;
  logic       reset;
  logic [3:0] raw;
  logic [3:0] clean;
  logic [3:0] held;
  logic       timer_busy;
  logic [1:0] grant_id;

  debounce_timer_arbiter #(.DELAY_CYCLES(D)) dut (
    .clk5       (clk5),
    .reset      (reset),
    .raw        (raw),
    .clean      (clean),
    .held       (held),
    .timer_busy (timer_busy),
    .grant_id   (grant_id)
  );

  always #100 clk5 = ~clk5;

  typedef enum int {K_CLEAN, K_HELD, K_BUSY, K_GRANT} kind_t;

  typedef struct {
    int         due;
    kind_t      kind;
    logic [3:0] value;
    string      name;
  } sb_t;

  typedef struct {
    int         ch;
    int         hold;
    logic [3:0] raw;
    logic [3:0] exp_clean;
    logic [3:0] exp_held;
    logic [3:0] exp_grant;
  } vec_t;

  sb_t  sb[$];
  vec_t vecs[4];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   pulse_cnt[4];

  task automatic check(string name, logic [3:0] actual, logic [3:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, actual, expected);
    end
  endtask

  task automatic sb_push(int delay, kind_t k, logic [3:0] v, string name);
    sb_t e;
    e.due   = cyc + delay;
    e.kind  = k;
    e.value = v;
    e.name  = name;
    sb.push_back(e);
  endtask

  function automatic logic [3:0] observe(kind_t k);
    case (k)
      K_CLEAN: return clean;
      K_HELD:  return held;
      K_BUSY:  return {3'b000, timer_busy};
      default: return {2'b00, grant_id};
    endcase
  endfunction

  function automatic int total_pulses();
    return pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3];
  endfunction

  // One clock: sample 1 time unit after the edge, then retire due expectations.
  task automatic step();
    @(posedge clk5);
    #1;
    cyc++;
    for (int b = 0; b < 4; b++) if (clean[b] === 1'b1) pulse_cnt[b]++;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        check(sb[i].name, observe(sb[i].kind), sb[i].value);
        sb.delete(i);
      end
    end
  endtask

  task automatic steps(int n);
    repeat (n) step();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    int p0;
    int t0;
    int r;

    for (int b = 0; b < 4; b++) pulse_cnt[b] = 0;
    vecs[0] = '{0, 40, 4'b0001, 4'b0001, 4'b0001, 4'd0};
    vecs[1] = '{1, 15, 4'b0010, 4'b0010, 4'b0010, 4'd1};
    vecs[2] = '{2, 20, 4'b0100, 4'b0100, 4'b0100, 4'd2};
    vecs[3] = '{3, 12, 4'b1000, 4'b1000, 4'b1000, 4'd3};

    // Reset state
    raw   = 4'b0000;
    reset = 1'b1;
    steps(3);
    check("reset_clean", clean, 4'b0000);
    check("reset_held", held, 4'b0000);
    check("reset_busy", {3'b000, timer_busy}, 4'd0);
    check("reset_grant", {2'b00, grant_id}, 4'd0);

    // Simultaneous press straight after reset: served 0,1,2,3
    reset = 1'b0;
    raw   = 4'b1111;
    sb_push(3,  K_CLEAN, 4'b1111, "sim_clean");
    sb_push(4,  K_CLEAN, 4'b0000, "sim_clean_end");
    sb_push(4,  K_GRANT, 4'd0,    "sim_grant0");
    sb_push(13, K_GRANT, 4'd1,    "sim_grant1");
    sb_push(22, K_GRANT, 4'd2,    "sim_grant2");
    sb_push(31, K_GRANT, 4'd3,    "sim_grant3");
    sb_push(4,  K_BUSY,  4'd1,    "sim_busy0_start");
    sb_push(11, K_BUSY,  4'd1,    "sim_busy0_last");
    sb_push(12, K_BUSY,  4'd0,    "sim_gap0");
    sb_push(21, K_BUSY,  4'd0,    "sim_gap1");
    sb_push(30, K_BUSY,  4'd0,    "sim_gap2");
    sb_push(39, K_BUSY,  4'd0,    "sim_gap3");
    sb_push(11, K_HELD,  4'b0000, "sim_held_none");
    sb_push(12, K_HELD,  4'b0001, "sim_held0");
    sb_push(21, K_HELD,  4'b0011, "sim_held1");
    sb_push(30, K_HELD,  4'b0111, "sim_held2");
    sb_push(39, K_HELD,  4'b1111, "sim_held3");
    steps(42);
    check("sim_pulse_total", 4'(total_pulses()), 4'd4);
    raw = 4'b0000;
    sb_push(2,  K_HELD,  4'b1111, "sim_rel_held");
    sb_push(3,  K_HELD,  4'b0000, "sim_rel_exit");
    sb_push(4,  K_GRANT, 4'd0,    "sim_rel_grant0");
    sb_push(31, K_GRANT, 4'd3,    "sim_rel_grant3");
    sb_push(40, K_BUSY,  4'd0,    "sim_rel_done");
    steps(45);

    // Table: uncontended press/hold/release on each channel
    foreach (vecs[v]) begin
      int ch_before;
      int all_before;
      ch_before  = pulse_cnt[vecs[v].ch];
      all_before = total_pulses();
      raw = vecs[v].raw;
      sb_push(2,  K_CLEAN, 4'b0000,          $sformatf("vec%0d_pre", v));
      sb_push(3,  K_CLEAN, vecs[v].exp_clean, $sformatf("vec%0d_clean", v));
      sb_push(4,  K_CLEAN, 4'b0000,          $sformatf("vec%0d_clean_end", v));
      sb_push(3,  K_BUSY,  4'd0,             $sformatf("vec%0d_busy_pre", v));
      sb_push(4,  K_BUSY,  4'd1,             $sformatf("vec%0d_busy_on", v));
      sb_push(4,  K_GRANT, vecs[v].exp_grant, $sformatf("vec%0d_grant", v));
      sb_push(11, K_BUSY,  4'd1,             $sformatf("vec%0d_busy_last", v));
      sb_push(11, K_HELD,  4'b0000,          $sformatf("vec%0d_held_pre", v));
      sb_push(12, K_HELD,  vecs[v].exp_held,  $sformatf("vec%0d_held", v));
      sb_push(12, K_BUSY,  4'd0,             $sformatf("vec%0d_busy_off", v));
      steps(vecs[v].hold);
      raw = 4'b0000;
      sb_push(2,  K_HELD,  vecs[v].exp_held,  $sformatf("vec%0d_rel_held", v));
      sb_push(3,  K_HELD,  4'b0000,          $sformatf("vec%0d_rel_exit", v));
      sb_push(4,  K_BUSY,  4'd1,             $sformatf("vec%0d_rel_busy_on", v));
      sb_push(4,  K_GRANT, vecs[v].exp_grant, $sformatf("vec%0d_rel_grant", v));
      sb_push(11, K_BUSY,  4'd1,             $sformatf("vec%0d_rel_busy_last", v));
      sb_push(12, K_BUSY,  4'd0,             $sformatf("vec%0d_rel_busy_off", v));
      steps(14);
      check($sformatf("vec%0d_pulses", v), 4'(pulse_cnt[vecs[v].ch] - ch_before), 4'd1);
      check($sformatf("vec%0d_pulses_all", v), 4'(total_pulses() - all_before), 4'd1);
    end

    // Bounce on press and on release of channel 1
    p0 = total_pulses();
    sb_push(3,  K_CLEAN, 4'b0010, "bounce_clean");
    sb_push(4,  K_CLEAN, 4'b0000, "bounce_clean_end");
    sb_push(12, K_HELD,  4'b0010, "bounce_held");
    for (int k = 0; k < 6; k++) begin
      raw[1] = (k % 2 == 0);
      step();
    end
    raw[1] = 1'b1;
    steps(14);
    sb_push(2,  K_HELD, 4'b0010, "bounce_rel_held");
    sb_push(3,  K_HELD, 4'b0000, "bounce_rel_exit");
    sb_push(4,  K_BUSY, 4'd1,    "bounce_rel_busy");
    sb_push(12, K_BUSY, 4'd0,    "bounce_rel_done");
    sb_push(20, K_HELD, 4'b0000, "bounce_final_held");
    sb_push(20, K_BUSY, 4'd0,    "bounce_final_busy");
    for (int k = 0; k < 6; k++) begin
      raw[1] = (k % 2 == 1);
      step();
    end
    raw[1] = 1'b0;
    steps(16);
    check("bounce_pulses", 4'(total_pulses() - p0), 4'd1);

    // Release during REQ_P: one cycle in HELD, then the release lockout
    p0  = total_pulses();
    raw = 4'b1000;
    sb_push(3,  K_CLEAN, 4'b1000, "relp_clean");
    sb_push(11, K_HELD,  4'b0000, "relp_held_pre");
    sb_push(12, K_HELD,  4'b1000, "relp_held");
    sb_push(13, K_HELD,  4'b0000, "relp_held_exit");
    sb_push(13, K_BUSY,  4'd0,    "relp_idle_gap");
    sb_push(14, K_BUSY,  4'd1,    "relp_busy_on");
    sb_push(21, K_BUSY,  4'd1,    "relp_busy_last");
    sb_push(22, K_BUSY,  4'd0,    "relp_busy_off");
    steps(5);
    raw = 4'b0000;
    steps(20);
    check("relp_pulses", 4'(total_pulses() - p0), 4'd1);

    // Re-press during REQ_R: seen in IDLE once the release lockout ends
    p0  = pulse_cnt[0];
    raw = 4'b0001;
    steps(15);
    raw = 4'b0000;
    sb_push(2,  K_HELD,  4'b0001, "repress_held");
    sb_push(3,  K_HELD,  4'b0000, "repress_exit");
    sb_push(4,  K_BUSY,  4'd1,    "repress_busy_on");
    sb_push(12, K_BUSY,  4'd0,    "repress_done");
    sb_push(12, K_CLEAN, 4'b0000, "repress_no_early");
    sb_push(13, K_CLEAN, 4'b0001, "repress_clean");
    sb_push(13, K_BUSY,  4'd0,    "repress_idle_gap");
    sb_push(14, K_BUSY,  4'd1,    "repress_busy2");
    sb_push(22, K_HELD,  4'b0001, "repress_held2");
    steps(5);
    raw = 4'b0001;
    steps(20);
    raw = 4'b0000;
    steps(16);
    check("repress_pulses", 4'(pulse_cnt[0] - p0), 4'd2);

    // Round-robin fairness: after channel 1, channel 2 beats channel 0
    raw = 4'b0010;
    steps(14);
    raw = 4'b0111;
    sb_push(3,  K_CLEAN, 4'b0101, "rr_clean");
    sb_push(4,  K_CLEAN, 4'b0000, "rr_clean_end");
    sb_push(4,  K_GRANT, 4'd2,    "rr_first_grant");
    sb_push(12, K_BUSY,  4'd0,    "rr_gap");
    sb_push(12, K_HELD,  4'b0110, "rr_held_first");
    sb_push(13, K_GRANT, 4'd0,    "rr_second_grant");
    sb_push(21, K_HELD,  4'b0111, "rr_held_second");
    steps(24);
    raw = 4'b0000;
    steps(45);

    // Press during another channel's lockout
    t0  = cyc;
    raw = 4'b0001;
    sb_push(3,  K_CLEAN, 4'b0001, "lock_clean0");
    sb_push(4,  K_CLEAN, 4'b0000, "lock_clean0_end");
    sb_push(6,  K_CLEAN, 4'b0010, "lock_clean1");
    sb_push(7,  K_CLEAN, 4'b0000, "lock_clean1_end");
    sb_push(4,  K_GRANT, 4'd0,    "lock_grant0");
    sb_push(12, K_GRANT, 4'd0,    "lock_grant_hold");
    sb_push(12, K_BUSY,  4'd0,    "lock_gap");
    sb_push(12, K_HELD,  4'b0001, "lock_held0");
    sb_push(13, K_GRANT, 4'd1,    "lock_grant1");
    sb_push(13, K_BUSY,  4'd1,    "lock_busy1_on");
    sb_push(20, K_BUSY,  4'd1,    "lock_busy1_last");
    sb_push(21, K_BUSY,  4'd0,    "lock_busy1_off");
    sb_push(21, K_HELD,  4'b0011, "lock_held1");
    steps(3);
    raw = 4'b0011;
    steps(22);
    raw = 4'b0000;
    steps(40);

    // Reset mid-lockout at count 4 with raw[2] still pressed
    raw = 4'b0100;
    steps(8);
    reset = 1'b1;
    step();
    check("rst_clean", clean, 4'b0000);
    check("rst_held", held, 4'b0000);
    check("rst_busy", {3'b000, timer_busy}, 4'd0);
    check("rst_grant", {2'b00, grant_id}, 4'd0);
    reset = 1'b0;
    sb_push(2,  K_CLEAN, 4'b0000, "rst_no_early");
    sb_push(3,  K_CLEAN, 4'b0100, "rst_new_clean");
    sb_push(4,  K_CLEAN, 4'b0000, "rst_new_clean_end");
    sb_push(3,  K_BUSY,  4'd0,    "rst_busy_pre");
    sb_push(4,  K_BUSY,  4'd1,    "rst_busy_on");
    sb_push(4,  K_GRANT, 4'd2,    "rst_grant2");
    sb_push(12, K_HELD,  4'b0100, "rst_held");
    steps(14);
    raw = 4'b0000;
    steps(16);

    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drained: %0d expectations left, expected 0 (t0=%0d r=%0d)", sb.size(), t0, r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
